debug_cmd_decoder: RTL and testbench
====================================

Name: debug_cmd_decoder

Overview:
Upstream driver of the pipeline debug-enable stage. It decodes single-byte commands from the UART receiver and produces the `o_continue` level and `o_valid` step pulses that the debug-enable stage turns into `o_debug_enb`. After each command it returns one ACK or NAK byte to the UART transmitter. Sits between the UART RX/TX and the debug-enable stage.

Parameters:
- STEP_HIGH, 2, cycles `o_valid` stays high per step (≥1)
- STEP_LOW, 2, cycles `o_valid` stays low between steps (≥1); gives the downstream edge detector a clean low
- ARG_TIMEOUT, 1000000, cycles to wait for a step-count byte before NAK (≥2)
- ACK_BYTE, 8'h06, reply on success
- NAK_BYTE, 8'h15, reply on failure

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-low reset
- i_rx_data  in  8  received byte, valid when `i_rx_done`=1
- i_rx_done  in  1  one-cycle pulse: `i_rx_data` valid
- i_tx_done  in  1  one-cycle pulse: transmitter finished current byte
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle pulse: start transmitting `o_tx_data`
- o_continue  out  1  1 = free-running, 0 = step mode
- o_valid  out  1  step pulse toward debug-enable stage
- o_busy  out  1  1 when state is not IDLE
- o_overrun  out  1  sticky: byte received while busy

Behaviour:
- Reset (async, `i_rst`=0):
  - state=IDLE
  - `o_continue`=0, `o_valid`=0, `o_tx_start`=0, `o_tx_data`=8'h00, `o_overrun`=0
  - step counter=0, timeout counter=0
  - Reset mid-operation aborts everything, including a pending reply.
- All outputs are registered; `o_busy` = (state != IDLE).
- States: IDLE, GET_ARG, STEP_HI, STEP_LO, SEND, WAIT_TX.
- IDLE, on `i_rx_done`:
  - 'C' (8'h43): `o_continue`<=1; reply ACK → SEND.
  - 'H' (8'h48): `o_continue`<=0, `o_overrun`<=0; reply ACK → SEND.
  - 'S' (8'h53): if `o_continue`=1, reply NAK → SEND. Otherwise clear the timeout counter → GET_ARG.
  - Any other byte: reply NAK → SEND.
- GET_ARG:
  - On `i_rx_done`, latch N=`i_rx_data`.
    - N=0: reply ACK → SEND.
    - N≠0: count<=N, `o_valid`<=1 → STEP_HI.
  - Timeout counter increments each cycle. Reaching ARG_TIMEOUT without a byte → reply NAK → SEND.
- STEP_HI:
  - `o_valid`=1 for exactly STEP_HIGH cycles, then `o_valid`<=0, count<=count−1 → STEP_LO.
- STEP_LO:
  - `o_valid`=0 for exactly STEP_LOW cycles.
  - Then, if count=0: reply ACK → SEND; else `o_valid`<=1 → STEP_HI.
  - N steps therefore produce exactly N rising edges; total duration N·(STEP_HIGH+STEP_LOW) cycles.
- SEND:
  - `o_tx_data`<=reply byte, `o_tx_start`=1 for one cycle → WAIT_TX.
- WAIT_TX:
  - Wait for `i_tx_done` → IDLE.
  - `i_tx_done` in any other state is ignored.
- Busy bytes: an `i_rx_done` in STEP_HI, STEP_LO, SEND or WAIT_TX is dropped and sets `o_overrun`<=1. Only 'H' in IDLE or reset clears it.
- Latency:
  - 'C'/'H' reply: `o_tx_start` asserts 2 cycles after the `i_rx_done` cycle (IDLE→SEND, SEND pulse).
  - 'C' takes effect: `o_continue` changes on the clock edge after `i_rx_done`.
  - First step: `o_valid` rises on the clock edge after the count byte's `i_rx_done`.
- Simultaneous `i_rx_done` and timeout expiry in GET_ARG: the byte wins.
- `o_continue` is not changed by 'S' and is held through all step activity.

Test Plan:
- Reset, then 'C' → `o_continue`=1 one edge after `i_rx_done`; `o_tx_start` pulse with `o_tx_data`=8'h06; after `i_tx_done`, `o_busy`=0.
- 'H', then 'S', then 8'h03 (STEP_HIGH=STEP_LOW=2) → `o_valid` high/low 2/2 cycles, exactly 3 rising edges over 12 cycles, then ACK 8'h06; `o_continue` stays 0.
- 'C', then 'S' → NAK 8'h15, no `o_valid` activity; 'S' then 8'h00 in step mode → ACK, no `o_valid`.
- 'S' with no count byte, ARG_TIMEOUT=10 → NAK 10 cycles later; unknown byte 8'h41 → NAK.
- 'S', 8'h05, plus an extra byte mid-stepping → steps still total 5, `o_overrun`=1; a following 'H' → `o_overrun`=0, ACK.
- Assert `i_rst` during STEP_HI with count=4 → `o_valid` and `o_continue` drop to 0 immediately, no reply sent; a new 'C' works normally after reset.

Source files
------------

// File: rtl/debug_cmd_decoder.sv
// Purpose: decodes single-byte UART debug commands into continue/step controls and replies ACK/NAK.
// Latency: C/H reply pulses o_tx_start 2 cycles after i_rx_done; first step rises 1 edge after the count byte.
// Backpressure: one command at a time; bytes arriving while stepping or replying are dropped and flag o_overrun.
module debug_cmd_decoder #(
    parameter int          STEP_HIGH   = 2,
    parameter int          STEP_LOW    = 2,
    parameter int          ARG_TIMEOUT = 1000000,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    input  logic       i_tx_done,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_continue,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_overrun
);

    localparam int HOLD_MAX = (STEP_HIGH > STEP_LOW) ? STEP_HIGH : STEP_LOW;
    localparam int HW       = $clog2(HOLD_MAX + 1);
    localparam int TW       = $clog2(ARG_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, GET_ARG, STEP_HI, STEP_LO, SEND, WAIT_TX
    } state_t;

    state_t          r_state,     w_state_nxt;
    logic [7:0]      r_cnt,       w_cnt_nxt;
    logic [HW-1:0]   r_hold,      w_hold_nxt;
    logic [TW-1:0]   r_tmo,       w_tmo_nxt;
    logic [7:0]      r_reply,     w_reply_nxt;
    logic            r_continue,  w_continue_nxt;
    logic            r_valid,     w_valid_nxt;
    logic            r_tx_start,  w_tx_start_nxt;
    logic [7:0]      r_tx_data,   w_tx_data_nxt;
    logic            r_overrun,   w_overrun_nxt;

    // State and registered outputs; reset aborts any step train or pending reply.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_tmo      <= '0;
            r_reply    <= 8'h00;
            r_continue <= 1'b0;
            r_valid    <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hold     <= w_hold_nxt;
            r_tmo      <= w_tmo_nxt;
            r_reply    <= w_reply_nxt;
            r_continue <= w_continue_nxt;
            r_valid    <= w_valid_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    // Next-state and next-output decode for the command FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hold_nxt     = r_hold;
        w_tmo_nxt      = r_tmo;
        w_reply_nxt    = r_reply;
        w_continue_nxt = r_continue;
        w_valid_nxt    = r_valid;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_overrun_nxt  = r_overrun;

        case (r_state)
            IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        8'h43: begin
                            w_continue_nxt = 1'b1;
                            w_reply_nxt    = ACK_BYTE;
                            w_state_nxt    = SEND;
                        end
                        8'h48: begin
                            w_continue_nxt = 1'b0;
                            w_overrun_nxt  = 1'b0;
                            w_reply_nxt    = ACK_BYTE;
                            w_state_nxt    = SEND;
                        end
                        8'h53: begin
                            // Stepping only makes sense while halted.
                            if (r_continue) begin
                                w_reply_nxt = NAK_BYTE;
                                w_state_nxt = SEND;
                            end else begin
                                w_tmo_nxt   = '0;
                                w_state_nxt = GET_ARG;
                            end
                        end
                        default: begin
                            w_reply_nxt = NAK_BYTE;
                            w_state_nxt = SEND;
                        end
                    endcase
                end
            end
            GET_ARG: begin
                // A byte arriving on the expiry cycle still wins over the timeout.
                if (i_rx_done) begin
                    if (i_rx_data == 8'h00) begin
                        w_reply_nxt = ACK_BYTE;
                        w_state_nxt = SEND;
                    end else begin
                        w_cnt_nxt   = i_rx_data;
                        w_valid_nxt = 1'b1;
                        w_hold_nxt  = '0;
                        w_state_nxt = STEP_HI;
                    end
                end else if (r_tmo == TW'(ARG_TIMEOUT - 1)) begin
                    w_reply_nxt = NAK_BYTE;
                    w_state_nxt = SEND;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            STEP_HI: begin
                if (r_hold == HW'(STEP_HIGH - 1)) begin
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = r_cnt - 8'd1;
                    w_hold_nxt  = '0;
                    w_state_nxt = STEP_LO;
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            STEP_LO: begin
                if (r_hold == HW'(STEP_LOW - 1)) begin
                    w_hold_nxt = '0;
                    if (r_cnt == 8'd0) begin
                        w_reply_nxt = ACK_BYTE;
                        w_state_nxt = SEND;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = STEP_HI;
                    end
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            SEND: begin
                w_tx_data_nxt  = r_reply;
                w_tx_start_nxt = 1'b1;
                w_state_nxt    = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Bytes that arrive while stepping or replying are lost; remember that it happened.
        if (i_rx_done && (r_state == STEP_HI || r_state == STEP_LO ||
                          r_state == SEND    || r_state == WAIT_TX)) begin
            w_overrun_nxt = 1'b1;
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_continue = r_continue;
    assign o_valid    = r_valid;
    assign o_overrun  = r_overrun;
    assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Purpose: directed bench for debug_cmd_decoder with a reply-byte scoreboard and step-edge counter.
// Latency: checks C reply timing, first-step timing and argument timeout timing.
// Backpressure: a simple UART TX model answers each o_tx_start with i_tx_done a few cycles later.
module tb_debug_cmd_decoder;

    localparam int STEP_HIGH   = 2;
    localparam int STEP_LOW    = 2;
    localparam int ARG_TIMEOUT = 10;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_continue;
    logic       o_valid;
    logic       o_busy;
    logic       o_overrun;

    debug_cmd_decoder #(
        .STEP_HIGH   (STEP_HIGH),
        .STEP_LOW    (STEP_LOW),
        .ARG_TIMEOUT (ARG_TIMEOUT),
        .ACK_BYTE    (8'h06),
        .NAK_BYTE    (8'h15)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_continue (o_continue),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         rises    = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(posedge i_clk);
        #1;
        i_rx_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge i_clk);
        while (o_busy && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    // Scoreboard: every reply byte the DUT starts must match the oldest expected one.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_tx_start) begin
                if (exp_q.size() == 0)
                    check("tx_unexpected", 32'(o_tx_data), 32'hFFFF);
                else
                    check("tx_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Step monitor: counts rising edges of o_valid.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_valid && !prev_valid) rises++;
            prev_valid = o_valid;
        end
    end

    // UART TX model: acknowledges each transmit start a few cycles later.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_tx_start) begin
                repeat (3) @(posedge i_clk);
                #1 i_tx_done = 1'b1;
                @(posedge i_clk);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        logic [11:0] vpat;
        logic [11:0] vexp;
        int          lat;

        i_rst     = 1'b0;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_continue", 32'(o_continue), 32'd0);
        check("rst_valid",    32'(o_valid),    32'd0);
        check("rst_tx_start", 32'(o_tx_start), 32'd0);
        check("rst_tx_data",  32'(o_tx_data),  32'h00);
        check("rst_overrun",  32'(o_overrun),  32'd0);
        check("rst_busy",     32'(o_busy),     32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b1;

        // 'C': continue on the next edge, ACK start two cycles after the byte.
        exp_q.push_back(8'h06);
        send_byte(8'h43);
        check("c_continue", 32'(o_continue), 32'd1);
        @(negedge i_clk);
        check("c_start_early", 32'(o_tx_start), 32'd0);
        @(negedge i_clk);
        check("c_start", 32'(o_tx_start), 32'd1);
        check("c_data",  32'(o_tx_data),  32'h06);
        wait_idle("c_idle");
        check("c_busy", 32'(o_busy), 32'd0);

        // 'H', 'S', 3 steps: 2 high / 2 low per step.
        exp_q.push_back(8'h06);
        send_byte(8'h48);
        check("h_continue", 32'(o_continue), 32'd0);
        wait_idle("h_idle");
        rises = 0;
        send_byte(8'h53);
        check("s_busy", 32'(o_busy), 32'd1);
        exp_q.push_back(8'h06);
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            vpat[i] = o_valid;
            vexp[i] = ((i % (STEP_HIGH + STEP_LOW)) < STEP_HIGH);
        end
        check("step3_pattern", 32'(vpat), 32'(vexp));
        wait_idle("step3_idle");
        check("step3_rises", rises, 3);
        check("step3_continue", 32'(o_continue), 32'd0);

        // 'S' in continue mode is refused; 'S' 0 in step mode acks without stepping.
        exp_q.push_back(8'h06);
        send_byte(8'h43);
        wait_idle("c2_idle");
        rises = 0;
        exp_q.push_back(8'h15);
        send_byte(8'h53);
        wait_idle("s_nak_idle");
        check("s_nak_rises", rises, 0);
        check("s_nak_continue", 32'(o_continue), 32'd1);
        exp_q.push_back(8'h06);
        send_byte(8'h48);
        wait_idle("h2_idle");
        send_byte(8'h53);
        exp_q.push_back(8'h06);
        send_byte(8'h00);
        wait_idle("s0_idle");
        check("s0_rises", rises, 0);

        // Missing count byte: ARG_TIMEOUT cycles in GET_ARG, one in SEND, then the pulse.
        exp_q.push_back(8'h15);
        send_byte(8'h53);
        lat = 0;
        while (lat < 100) begin
            @(negedge i_clk);
            lat++;
            if (o_tx_start) break;
        end
        check("tmo_latency", lat, ARG_TIMEOUT + 2);
        wait_idle("tmo_idle");
        exp_q.push_back(8'h15);
        send_byte(8'h41);
        wait_idle("unk_idle");

        // Extra byte during stepping is dropped and sets the sticky overrun flag.
        rises = 0;
        send_byte(8'h53);
        exp_q.push_back(8'h06);
        send_byte(8'h05);
        repeat (3) @(posedge i_clk);
        send_byte(8'h58);
        check("ovr_set", 32'(o_overrun), 32'd1);
        wait_idle("ovr_idle");
        check("ovr_rises", rises, 5);
        check("ovr_sticky", 32'(o_overrun), 32'd1);
        exp_q.push_back(8'h06);
        send_byte(8'h48);
        check("ovr_clear", 32'(o_overrun), 32'd0);
        wait_idle("h3_idle");

        // Reset in the middle of a step train aborts it with no reply.
        send_byte(8'h53);
        send_byte(8'h04);
        @(negedge i_clk);
        check("rst_mid_valid_hi", 32'(o_valid), 32'd1);
        #2 i_rst = 1'b0;
        #1;
        check("rst_mid_valid",    32'(o_valid),    32'd0);
        check("rst_mid_continue", 32'(o_continue), 32'd0);
        check("rst_mid_busy",     32'(o_busy),     32'd0);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b1;
        repeat (20) @(posedge i_clk);
        exp_q.push_back(8'h06);
        send_byte(8'h43);
        check("post_rst_continue", 32'(o_continue), 32'd1);
        wait_idle("post_rst_idle");

        repeat (5) @(posedge i_clk);
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
